// File: rtl/load_store_unit_if.sv
// Bus bundle between the core memory stage, the load/store unit and the data memory.
//   slave  : load_store_unit view (takes requests, drives the memory port)
//   master : environment view (core side issues requests, memory returns read data)
// Request : req_valid/req_ready handshake, req_we, funct3, addr, wdata
// Response: rsp_valid pulse with rdata and misalign
// Memory  : mem_add (word index), mem_data_in, mem_wen, mem_data_out (combinational read)
interface load_store_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic             rsp_valid;
    logic [WIDTH-1:0] rdata;
    logic             misalign;
    logic [WIDTH-1:0] mem_add;
    logic [WIDTH-1:0] mem_data_in;
    logic             mem_wen;
    logic [WIDTH-1:0] mem_data_out;

    modport slave (
        input  req_valid, req_we, funct3, addr, wdata, mem_data_out,
        output req_ready, rsp_valid, rdata, misalign, mem_add, mem_data_in, mem_wen
    );

    modport master (
        output req_valid, req_we, funct3, addr, wdata, mem_data_out,
        input  req_ready, rsp_valid, rdata, misalign, mem_add, mem_data_in, mem_wen
    );
endinterface

// File: rtl/load_store_unit.sv
// Word-to-byte bridge between the core memory stage and a word-only data memory.
// Handles one RV32I load/store at a time: lane select and extension on loads,
// read-modify-write for byte/halfword stores, and fault detection before any
// memory access.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : load_store_unit_if.slave (request, response and memory port)
module load_store_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic               clk,
    input logic               rst,
    load_store_unit_if.slave  bus
);
    localparam logic [2:0] F3B  = 3'b000;
    localparam logic [2:0] F3H  = 3'b001;
    localparam logic [2:0] F3W  = 3'b010;
    localparam logic [2:0] F3BU = 3'b100;
    localparam logic [2:0] F3HU = 3'b101;

    typedef enum logic [2:0] {StIdle, StLoad, StRmw, StWrite, StResp} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] merge_q, merge_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             misalign_q, misalign_d;

    logic             fault;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [WIDTH-1:0] load_ext;
    logic [WIDTH-1:0] merged;

    // Fault decode on the live request; only meaningful at the accept edge.
    always_comb begin
        logic legal_f3;
        logic bad_align;
        if (bus.req_we) begin
            legal_f3 = (bus.funct3 == F3B) || (bus.funct3 == F3H) || (bus.funct3 == F3W);
        end else begin
            legal_f3 = (bus.funct3 == F3B) || (bus.funct3 == F3H) || (bus.funct3 == F3W) ||
                       (bus.funct3 == F3BU) || (bus.funct3 == F3HU);
        end
        // funct3[1:0] 01 covers H/HU, 10 covers W
        bad_align = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                    ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
        fault = !legal_f3 || bad_align;
    end

    // Load lane selection and extension from the registered address.
    always_comb begin
        ld_byte = bus.mem_data_out[{addr_q[1:0], 3'b000} +: 8];
        ld_half = bus.mem_data_out[{addr_q[1], 4'b0000} +: 16];
        case (funct3_q)
            F3B:     load_ext = {{(WIDTH-8){ld_byte[7]}}, ld_byte};
            F3H:     load_ext = {{(WIDTH-16){ld_half[15]}}, ld_half};
            F3BU:    load_ext = {{(WIDTH-8){1'b0}}, ld_byte};
            F3HU:    load_ext = {{(WIDTH-16){1'b0}}, ld_half};
            default: load_ext = bus.mem_data_out;
        endcase
    end

    // Read-modify-write merge: replace only the target lane of the read word.
    always_comb begin
        merged = bus.mem_data_out;
        if (funct3_q[0]) begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end else begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        funct3_d   = funct3_q;
        wdata_d    = wdata_q;
        merge_d    = merge_q;
        rdata_d    = rdata_q;
        misalign_d = misalign_q;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    addr_d     = bus.addr;
                    funct3_d   = bus.funct3;
                    wdata_d    = bus.wdata;
                    rdata_d    = '0;
                    misalign_d = fault;
                    if (fault) begin
                        state_d = StResp;
                    end else if (!bus.req_we) begin
                        state_d = StLoad;
                    end else if (bus.funct3 == F3W) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRmw;
                    end
                end
            end
            StLoad: begin
                rdata_d = load_ext;
                state_d = StResp;
            end
            StRmw: begin
                merge_d = merged;
                state_d = StWrite;
            end
            StWrite: state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            funct3_q   <= '0;
            wdata_q    <= '0;
            merge_q    <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            funct3_q   <= funct3_d;
            wdata_q    <= wdata_d;
            merge_q    <= merge_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
        end
    end

    // Only a legal word store reaches WRITE with funct3 == W; SB/SH write the merge word.
    assign bus.req_ready   = (state_q == StIdle);
    assign bus.rsp_valid   = (state_q == StResp);
    assign bus.rdata       = rdata_q;
    assign bus.misalign    = misalign_q;
    assign bus.mem_add     = {2'b00, addr_q[WIDTH-1:2]};
    assign bus.mem_wen     = (state_q == StWrite);
    assign bus.mem_data_in = (funct3_q == F3W) ? wdata_q : merge_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory behind the port.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   wen_cnt = 0;
    logic [31:0] last_wen_addr = '0;

    logic [31:0] mem [0:15];
    logic        bd_we = 1'b0;
    logic [3:0]  bd_addr = '0;
    logic [31:0] bd_data = '0;

    load_store_unit_if #(.WIDTH(32)) bus ();

    load_store_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_data_out = mem[bus.mem_add[3:0]];

    always @(posedge clk) begin
        if (bus.mem_wen) mem[bus.mem_add[3:0]] <= bus.mem_data_in;
        else if (bd_we) mem[bd_addr] <= bd_data;
    end

    always @(negedge clk) begin
        if (bus.mem_wen) begin
            wen_cnt       <= wen_cnt + 1;
            last_wen_addr <= bus.mem_add;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic backdoor(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input int exp_lat,
                          input logic [31:0] exp_rd, input logic exp_mis, input int exp_wen);
        int lat;
        int w0;
        int busy_bad;
        @(negedge clk);
        bus.req_we = we; bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
        bus.req_valid = 1'b1;
        chk({tag, " ready"}, {31'd0, bus.req_ready}, 32'd1);
        w0 = wen_cnt;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        busy_bad = 0;
        while (!bus.rsp_valid && lat < 10) begin
            if (bus.req_ready) busy_bad++;
            @(negedge clk);
            lat++;
        end
        if (bus.req_ready) busy_bad++;
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " rdata"}, bus.rdata, exp_rd);
        chk({tag, " misalign"}, {31'd0, bus.misalign}, {31'd0, exp_mis});
        chk({tag, " writes"}, wen_cnt - w0, exp_wen);
        chk({tag, " busy ready"}, busy_bad, 0);
        @(negedge clk);
        chk({tag, " rsp pulse"}, {31'd0, bus.rsp_valid}, 32'd0);
    endtask

    initial begin
        int w0;
        int n;
        int rsp_n;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.funct3 = '0;
        bus.addr = '0; bus.wdata = '0;
        #1 rst = 1'b1;
        #1;
        chk("reset ready", {31'd0, bus.req_ready}, 32'd1);
        chk("reset rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("reset rdata", bus.rdata, 32'd0);
        chk("reset misalign", {31'd0, bus.misalign}, 32'd0);
        chk("reset mem_wen", {31'd0, bus.mem_wen}, 32'd0);
        chk("reset mem_add", bus.mem_add, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        backdoor(4'd0, 32'h0);
        backdoor(4'd1, 32'hAABBCCDD);
        backdoor(4'd2, 32'h11223384);
        backdoor(4'd3, 32'h0);

        // Reset while in RMW: nothing may be written and no response produced.
        @(negedge clk);
        bus.req_we = 1'b1; bus.funct3 = 3'b000; bus.addr = 32'h5; bus.wdata = 32'h12345677;
        bus.req_valid = 1'b1;
        w0 = wen_cnt;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst mid mem_wen", {31'd0, bus.mem_wen}, 32'd0);
        chk("rst mid rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst mid ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst mid mem_add", bus.mem_add, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst mid no rsp", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst mid mem word", mem[1], 32'hAABBCCDD);
        chk("rst mid writes", wen_cnt - w0, 0);

        do_req("sw0", 1'b1, 3'b010, 32'h0, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1);
        chk("sw0 wen addr", last_wen_addr, 32'h0);
        do_req("lw0", 1'b0, 3'b010, 32'h0, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0);

        do_req("lb b", 1'b0, 3'b000, 32'hB, 32'h0, 2, 32'h00000011, 1'b0, 0);
        do_req("lb 8", 1'b0, 3'b000, 32'h8, 32'h0, 2, 32'hFFFFFF84, 1'b0, 0);
        do_req("lbu 8", 1'b0, 3'b100, 32'h8, 32'h0, 2, 32'h00000084, 1'b0, 0);
        do_req("lh a", 1'b0, 3'b001, 32'hA, 32'h0, 2, 32'h00001122, 1'b0, 0);
        do_req("lhu 8", 1'b0, 3'b101, 32'h8, 32'h0, 2, 32'h00003384, 1'b0, 0);

        do_req("sb 5", 1'b1, 3'b000, 32'h5, 32'h12345677, 3, 32'h0, 1'b0, 1);
        chk("sb 5 wen addr", last_wen_addr, 32'h1);
        do_req("lw 4 after sb", 1'b0, 3'b010, 32'h4, 32'h0, 2, 32'hAABB77DD, 1'b0, 0);

        backdoor(4'd1, 32'hAABBCCDD);
        do_req("sh 6", 1'b1, 3'b001, 32'h6, 32'h0000BEEF, 3, 32'h0, 1'b0, 1);
        do_req("lw 4 after sh", 1'b0, 3'b010, 32'h4, 32'h0, 2, 32'hBEEFCCDD, 1'b0, 0);

        do_req("fault lw 2", 1'b0, 3'b010, 32'h2, 32'h0, 1, 32'h0, 1'b1, 0);
        do_req("fault sh 1", 1'b1, 3'b001, 32'h1, 32'hFFFF, 1, 32'h0, 1'b1, 0);
        do_req("fault ld 011", 1'b0, 3'b011, 32'h0, 32'h0, 1, 32'h0, 1'b1, 0);
        chk("fault mem word0", mem[0], 32'hDEADBEEF);

        // Back-to-back byte stores with req_valid held high throughout.
        backdoor(4'd0, 32'h0);
        @(negedge clk);
        bus.req_we = 1'b1; bus.funct3 = 3'b000; bus.addr = 32'h0; bus.wdata = 32'h11;
        bus.req_valid = 1'b1;
        w0 = wen_cnt;
        for (int i = 0; i < 4; i++) begin
            chk("b2b ready", {31'd0, bus.req_ready}, 32'd1);
            @(posedge clk);
            @(negedge clk);
            if (i < 3) begin
                bus.addr  = i + 1;
                bus.wdata = (i + 2) * 32'h11;
            end else begin
                bus.req_valid = 1'b0;
            end
            n = 0;
            rsp_n = 0;
            while (!bus.req_ready && n < 10) begin
                if (bus.rsp_valid) rsp_n++;
                n++;
                @(negedge clk);
            end
            chk("b2b busy cycles", n, 3);
            chk("b2b rsp count", rsp_n, 1);
        end
        chk("b2b writes", wen_cnt - w0, 4);
        do_req("b2b lw 0", 1'b0, 3'b010, 32'h0, 32'h0, 2, 32'h44332211, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Word-to-byte bridge between the core's memory stage and the single-port data memory. It accepts one RV32I load or store request at a time and drives the word-indexed data memory port. Loads are returned with byte/halfword lane selection and sign or zero extension. Byte and halfword stores are done as a read-modify-write, because the memory only performs whole-word writes. Misaligned or illegal accesses are flagged and never reach memory.

## Interface
- WIDTH, 32, data and address width; only 32 is supported.

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request; high only in IDLE
- req_we  input  1  1 = store, 0 = load
- funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  input  WIDTH  byte address
- wdata  input  WIDTH  store data; the byte or halfword is in the low bits
- rsp_valid  output  1  one-cycle completion pulse
- rdata  output  WIDTH  extended load data; 0 for stores and faults
- misalign  output  1  fault flag, valid with rsp_valid
- mem_add  output  WIDTH  word index into data memory, {2'b00, addr[31:2]}
- mem_data_in  output  WIDTH  write word to memory
- mem_wen  output  1  memory write enable, sampled by memory on the rising edge of clk
- mem_data_out  input  WIDTH  combinational read word from memory

## Operation
- States: IDLE, LOAD, RMW, WRITE, RESP.
- Accept: a request is accepted when req_valid and req_ready are both high at a clock edge. addr, funct3, req_we and wdata are then registered.
- Fault check at accept:
  - Loads are legal only for funct3 000, 001, 010, 100, 101.
  - Stores are legal only for funct3 000, 001, 010.
  - H/HU need addr[0]=0; W needs addr[1:0]=00.
  - On any fault, go to RESP with misalign=1, and never enter WRITE.
- Legal load: IDLE->LOAD->RESP.
  - In LOAD, mem_add comes from the registered address.
  - The lane is selected by addr[1:0]: byte lane = addr[1:0]*8; half lane = addr[1]*16.
  - Extension: B/H sign-extend, BU/HU zero-extend.
  - The result is registered into rdata on the LOAD->RESP edge.
- SW: IDLE->WRITE->RESP. In WRITE, mem_data_in = wdata and mem_wen=1.
- SB/SH: IDLE->RMW->WRITE->RESP.
  - In RMW, mem_data_out is captured into a merge register.
  - The target byte or halfword lane is replaced with wdata[7:0] or wdata[15:0]; all other lanes are preserved.
  - In WRITE, mem_data_in = merge register.
- RESP:
  - rsp_valid=1 for exactly one cycle, together with rdata and misalign.
  - For stores, rdata = 0.
  - Next state is IDLE.
- mem_wen is a decode of state == WRITE only, so there is exactly one write per legal store and none otherwise.
- mem_add always reflects the registered address, so it is stable across RMW and WRITE.

## Timing
- Reset (asynchronous, immediate) sets:
  - state = IDLE
  - rsp_valid=0, rdata=0, misalign=0
  - all capture and merge registers = 0
  - consequently req_ready=1, mem_wen=0, mem_add=0
- Latency in cycles from the accept edge to the rsp_valid cycle:
  - load 2
  - SW 2
  - SB/SH 3
  - fault 1
- req_ready is low from the cycle after accept through RESP. A new request can be accepted at the first edge after RESP.
- Request inputs are ignored while busy; no back-pressure is applied on the response path.
- Reset during LOAD/RMW/WRITE aborts the operation: mem_wen drops immediately and no response is produced.
- Memory contents change only at the WRITE->RESP edge.
- Same-word back-to-back stores are ordered. The second RMW reads the word already written by the first, because RESP separates them.

## Test plan
- Reset mid-RMW:
  - Assert rst during RMW.
  - Required: mem_wen never high, memory word unchanged, outputs return to reset values.
  - Then SW addr 0x00 wdata 0xDEADBEEF -> mem_wen high for one cycle with mem_add=0.
  - Then LW 0x00 -> rsp_valid 2 cycles after accept with rdata=0xDEADBEEF, misalign=0.
- Loads from word 0x11223384 stored at byte 0x8:
  - LB 0xB -> 0x00000011.
  - LB 0x8 -> 0xFFFFFF84.
  - LBU 0x8 -> 0x00000084.
  - LH 0xA -> 0x00001122.
  - LHU 0x8 -> 0x00003384.
- Byte store: word 0x4 = 0xAABBCCDD; SB 0x5 wdata 0x12345677.
  - Required: mem_wen exactly one cycle, 3-cycle latency.
  - LW 0x4 -> 0xAABB77DD.
- Halfword store: SH 0x6 wdata 0x0000BEEF onto word 0x4 = 0xAABBCCDD.
  - LW 0x4 -> 0xBEEFCCDD.
- Faults, each with no memory access:
  - LW 0x2, SH 0x1, and load funct3=011 each give: rsp_valid 1 cycle after accept, misalign=1, rdata=0, mem_wen never high.
- Back-to-back SB to bytes 0x0, 0x1, 0x2, 0x3 of a cleared word 0x0, with req_valid held high:
  - Each request is accepted as soon as req_ready is high.
  - LW 0x0 returns the combined word.
  - req_ready is low during every busy cycle.
